// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) constant multipliers and the InvMixColumns scheduler state type.
package aes_pkg;

    localparam logic [7:0] AES_POLY_RED = 8'h1b;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } imc_state_t;

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_RED : 8'h00);
    endfunction

    // Higher constants are built from the x2/x4/x8 doublings plus the identity term.
    function automatic logic [7:0] gm09(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ b;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(b) ^ b;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ b;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ gm2(b);
    endfunction

endpackage

// File: rtl/inv_mix_columns_sched_if.sv
// Input/output valid-ready channels of the InvMixColumns scheduler.
interface inv_mix_columns_sched_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_bypass;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_bypass, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_bypass, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/inv_mix_word.sv
// Combinational InvMixColumns on one 32-bit column, byte 0 in the MSB.
module inv_mix_word
    import aes_pkg::*;
(
    input  logic [31:0] w_i,
    output logic [31:0] w_o
);
    logic [7:0] b0, b1, b2, b3;

    assign b0 = w_i[31:24];
    assign b1 = w_i[23:16];
    assign b2 = w_i[15:8];
    assign b3 = w_i[7:0];

    assign w_o[31:24] = gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm09(b3);
    assign w_o[23:16] = gm09(b0) ^ gm14(b1) ^ gm11(b2) ^ gm13(b3);
    assign w_o[15:8]  = gm13(b0) ^ gm09(b1) ^ gm14(b2) ^ gm11(b3);
    assign w_o[7:0]   = gm11(b0) ^ gm13(b1) ^ gm09(b2) ^ gm14(b3);
endmodule

// File: rtl/inv_mix_columns_sched.sv
// Column-serial InvMixColumns: LANES word units sweep the four columns of one work register.
module inv_mix_columns_sched
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    inv_mix_columns_sched_if.slave  bus,
    output logic                    busy
);
    localparam logic [1:0] Step    = 2'(LANES);
    localparam logic [1:0] LastCol = 2'(4 - LANES);

    imc_state_t   state_q, state_d;
    logic [127:0] wr_q, wr_d;
    logic [1:0]   col_q, col_d;
    logic         accept;

    logic [1:0]  lane_col [LANES];
    logic [31:0] lane_in  [LANES];
    logic [31:0] lane_out [LANES];

    // Column c lives at bits [127-32c -: 32], i.e. base offset {~c, 5'd0}.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_col[k] = col_q + 2'(k);
        assign lane_in[k]  = wr_q[{~lane_col[k], 5'd0} +: 32];

        inv_mix_word u_word (
            .w_i (lane_in[k]),
            .w_o (lane_out[k])
        );
    end

    assign bus.in_ready  = rst_n && ((state_q == StIdle) ||
                                     ((state_q == StDone) && bus.out_ready));
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_data  = wr_q;
    assign busy          = (state_q == StCalc);
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        col_d   = col_q;

        unique case (state_q)
            StIdle: ;
            StCalc: begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    wr_d[{~lane_col[k], 5'd0} +: 32] = lane_out[k];
                end
                col_d = col_q + Step;
                if (col_q == LastCol) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // An accept in DONE overrides the return to IDLE, so back-to-back blocks see no bubble.
        if (accept) begin
            wr_d    = bus.in_data;
            col_d   = '0;
            state_d = bus.in_bypass ? StDone : StCalc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wr_q    <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            col_q   <= col_d;
        end
    end
endmodule

// File: tb/tb_inv_mix_columns_sched.sv
// Directed and scoreboarded checks of the InvMixColumns scheduler at LANES = 1, 2 and 4.
module tb_inv_mix_columns_sched;
    logic clk = 1'b0;
    logic rst_n;
    logic busy1, busy2, busy4;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    inv_mix_columns_sched_if if1 ();
    inv_mix_columns_sched_if if2 ();
    inv_mix_columns_sched_if if4 ();

    assign if2.in_valid  = if1.in_valid;
    assign if2.in_bypass = if1.in_bypass;
    assign if2.in_data   = if1.in_data;
    assign if2.out_ready = if1.out_ready;
    assign if4.in_valid  = if1.in_valid;
    assign if4.in_bypass = if1.in_bypass;
    assign if4.in_data   = if1.in_data;
    assign if4.out_ready = if1.out_ready;

    inv_mix_columns_sched #(.LANES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy1));
    inv_mix_columns_sched #(.LANES(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2), .busy(busy2));
    inv_mix_columns_sched #(.LANES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4), .busy(busy4));

    localparam logic [127:0] VecA  = {4{32'h8e4da1bc}};
    localparam logic [127:0] ExpA  = {4{32'hdb135345}};
    localparam logic [127:0] VecB  = {32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8, 32'hc6c6c6c6};
    localparam logic [127:0] ExpB  = {32'hf20a225c, 32'hd4d4d4d5, 32'h2d26314c, 32'hc6c6c6c6};
    localparam logic [127:0] VecC  = {32'h01010101, 32'hc6c6c6c6, 32'h01010101, 32'hc6c6c6c6};
    localparam logic [127:0] VecBy = 128'h0123456789abcdef0123456789abcdef;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] d, input logic byp);
        logic [127:0] r;
        logic [7:0]   s [4];
        logic [7:0]   m [4];
        if (byp) return d;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) s[j] = d[127 - 32*c - 8*j -: 8];
            for (int j = 0; j < 4; j++) begin
                m[j] = gmul(s[j], 8'd14) ^ gmul(s[(j+1)%4], 8'd11) ^
                       gmul(s[(j+2)%4], 8'd13) ^ gmul(s[(j+3)%4], 8'd9);
                r[127 - 32*c - 8*j -: 8] = m[j];
            end
        end
        return r;
    endfunction

    // One block into all three DUTs from IDLE; measures edges from accept to out_valid.
    task automatic run_block(input string tag, input logic [127:0] d, input logic byp,
                             input logic [127:0] exp);
        int lat1, lat2, lat4;
        logic [127:0] got1, got2, got4;
        logic busy_seen;
        lat1 = 99; lat2 = 99; lat4 = 99;
        got1 = '0; got2 = '0; got4 = '0;
        busy_seen = 1'b0;
        @(negedge clk);
        if1.in_valid = 1'b1; if1.in_data = d; if1.in_bypass = byp; if1.out_ready = 1'b1;
        @(negedge clk);
        if1.in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            busy_seen = busy_seen | busy1 | busy2 | busy4;
            if (if1.out_valid && lat1 == 99) begin lat1 = k; got1 = if1.out_data; end
            if (if2.out_valid && lat2 == 99) begin lat2 = k; got2 = if2.out_data; end
            if (if4.out_valid && lat4 == 99) begin lat4 = k; got4 = if4.out_data; end
        end
        check_eq({tag, " data L1"}, got1, exp);
        check_eq({tag, " data L2"}, got2, exp);
        check_eq({tag, " data L4"}, got4, exp);
        check_eq({tag, " lat L1"}, 128'(lat1), byp ? 128'd0 : 128'd4);
        check_eq({tag, " lat L2"}, 128'(lat2), byp ? 128'd0 : 128'd2);
        check_eq({tag, " lat L4"}, 128'(lat4), byp ? 128'd0 : 128'd1);
        if (byp) check_eq({tag, " busy never"}, 128'(busy_seen), 128'd0);
    endtask

    initial begin
        logic [127:0] exp_q [$];
        logic [127:0] held;
        logic         stalled;
        int           sent, got, lat;

        rst_n = 1'b0;
        if1.in_valid = 1'b0; if1.in_bypass = 1'b0; if1.in_data = '0; if1.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("reset out_valid", 128'(if1.out_valid), 128'd0);
        check_eq("reset busy", 128'(busy1), 128'd0);
        check_eq("reset out_data", if1.out_data, 128'd0);
        check_eq("reset in_ready gated", 128'(if1.in_ready), 128'd0);
        rst_n = 1'b1;
        #1 check_eq("idle in_ready", 128'(if1.in_ready), 128'd1);

        run_block("vecA", VecA, 1'b0, ExpA);
        run_block("vecB", VecB, 1'b0, ExpB);
        run_block("ident", VecC, 1'b0, VecC);
        run_block("bypass", VecBy, 1'b1, VecBy);

        // Backpressure on a finished block, then handoff with a same-edge accept.
        @(negedge clk);
        if1.out_ready = 1'b0; if1.in_valid = 1'b1; if1.in_data = VecA; if1.in_bypass = 1'b0;
        @(negedge clk);
        if1.in_valid = 1'b0;
        for (int k = 0; k < 10 && !if1.out_valid; k++) @(negedge clk);
        check_eq("bp reached done", 128'(if1.out_valid), 128'd1);
        for (int k = 0; k < 6; k++) begin
            check_eq("bp data stable", if1.out_data, ExpA);
            check_eq("bp in_ready low", 128'(if1.in_ready), 128'd0);
            @(negedge clk);
        end
        if1.out_ready = 1'b1; if1.in_valid = 1'b1; if1.in_data = VecB;
        #1 check_eq("handoff in_ready", 128'(if1.in_ready), 128'd1);
        @(negedge clk);
        if1.in_valid = 1'b0;
        check_eq("handoff busy", 128'(busy1), 128'd1);
        lat = 99;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (if1.out_valid && lat == 99) begin
                lat = k;
                check_eq("handoff data", if1.out_data, ExpB);
            end
        end
        check_eq("handoff latency", 128'(lat), 128'd4);

        // Reset asserted during the second CALC cycle.
        @(negedge clk);
        if1.in_valid = 1'b1; if1.in_data = VecA;
        @(negedge clk);
        if1.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst out_valid", 128'(if1.out_valid), 128'd0);
        check_eq("midrst busy", 128'(busy1), 128'd0);
        check_eq("midrst out_data", if1.out_data, 128'd0);
        check_eq("midrst in_ready", 128'(if1.in_ready), 128'd0);
        rst_n = 1'b1;
        run_block("post reset", VecA, 1'b0, ExpA);

        // Random traffic against the reference model.
        sent = 0; got = 0; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 3000 && (sent < 30 || exp_q.size() > 0); cyc++) begin
            @(negedge clk);
            if (stalled) begin
                check_eq("rand stall valid", 128'(if1.out_valid), 128'd1);
                check_eq("rand stall data", if1.out_data, held);
            end
            if1.in_valid  = (sent < 30) && ($urandom_range(0, 3) != 0);
            if1.in_bypass = ($urandom_range(0, 3) == 0);
            if1.in_data   = {$urandom, $urandom, $urandom, $urandom};
            if1.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            stalled = if1.out_valid && !if1.out_ready;
            held    = if1.out_data;
            if (if1.out_valid && if1.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("rand unexpected block", 128'd1, 128'd0);
                end else begin
                    check_eq("rand block", if1.out_data, exp_q.pop_front());
                    got++;
                end
            end
            if (if1.in_valid && if1.in_ready) begin
                exp_q.push_back(ref_model(if1.in_data, if1.in_bypass));
                sent++;
            end
        end
        check_eq("rand sent", 128'(sent), 128'd30);
        check_eq("rand received", 128'(got), 128'd30);
        check_eq("rand queue empty", 128'(exp_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
